// File: rtl/score_pkg.sv
// Shared definitions for the reaction-time read path.
//   SCORE_WIDTH / SCORE_DEPTH : default row width and row count of the register file
//   SCORE_MAX                 : all-ones score, used as the "no result yet" value
//   score_state_t             : read sequencer states
package score_pkg;

   localparam int unsigned SCORE_WIDTH = 13;
   localparam int unsigned SCORE_DEPTH = 8;

   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } score_state_t;

endpackage

// File: rtl/register_row_mux.sv
// Combinational row selector for the flattened register file outputs.
//   rows_flat : all rows, row k at bits [k*WIDTH +: WIDTH]
//   addr      : row index; indices >= DEPTH select zero
//   row       : selected row value
module register_row_mux
   import score_pkg::*;
#(
   parameter int unsigned WIDTH = SCORE_WIDTH,
   parameter int unsigned DEPTH = SCORE_DEPTH,
   parameter int unsigned AW    = 4
) (
   input  logic [WIDTH*DEPTH-1:0] rows_flat,
   input  logic [AW-1:0]          addr,
   output logic [WIDTH-1:0]       row
);

   always_comb begin
      row = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (addr == AW'(k)) begin
            row = rows_flat[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/score_reader.sv
// Read-side sequencer for the reaction-time register file. On Start it walks
// rows 0..min(Count,DEPTH)-1 and streams each row over a valid/ready interface,
// then pulses Done.
// Optional feature macro: SCORE_READER_BEST_EN adds the Best output (running
// minimum of the streamed beats, all-ones when nothing has been streamed).
// Ports:
//   Clock, Reset        : rising-edge clock, synchronous active-high reset
//   Start, Count        : begin a walk (sampled in IDLE), rows to read (latched)
//   RowsFlat            : flattened register rows, row k at [k*WIDTH +: WIDTH]
//   OutData/OutValid/OutLast, OutReady : output stream and consumer back-pressure
//   Busy, Done          : walk in progress, one-cycle completion pulse
//   Best                : (SCORE_READER_BEST_EN only) minimum accepted beat
module score_reader
   import score_pkg::*;
#(
   parameter int unsigned WIDTH = SCORE_WIDTH,
   parameter int unsigned DEPTH = SCORE_DEPTH,
   parameter int unsigned CNT_W = 4
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic [CNT_W-1:0]       Count,
   input  logic [WIDTH*DEPTH-1:0] RowsFlat,
   output logic [WIDTH-1:0]       OutData,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic                   OutLast,
   output logic                   Busy,
`ifdef SCORE_READER_BEST_EN
   output logic [WIDTH-1:0]       Best,
`endif
   output logic                   Done
);

   score_state_t     state, state_next;
   logic [CNT_W-1:0] addr;
   logic [CNT_W-1:0] num_rows;
   logic [CNT_W-1:0] count_clamped;
   logic [WIDTH-1:0] row;
   logic             handshake;

   register_row_mux #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (CNT_W)
   ) u_row_mux (
      .rows_flat (RowsFlat),
      .addr      (addr),
      .row       (row)
   );

   assign count_clamped = (Count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : Count;
   assign handshake     = (state == SEND) && OutValid && OutReady;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      Busy       = 1'b1;
      Done       = 1'b0;
      case (state)
         IDLE: begin
            Busy = 1'b0;
            if (Start) begin
               state_next = (count_clamped == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_next = SEND;
         SEND: begin
            if (handshake) begin
               state_next = OutLast ? DONE : FETCH;
            end
         end
         DONE: begin
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         OutData  <= '0;
         OutValid <= 1'b0;
         OutLast  <= 1'b0;
         addr     <= '0;
         num_rows <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  num_rows <= count_clamped;
                  addr     <= '0;
               end
            end
            FETCH: begin
               OutData  <= row;
               OutLast  <= (addr == num_rows - CNT_W'(1));
               OutValid <= 1'b1;
            end
            SEND: begin
               if (handshake) begin
                  OutValid <= 1'b0;
                  if (!OutLast) begin
                     addr <= addr + CNT_W'(1);
                  end
               end
            end
            DONE: OutLast <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef SCORE_READER_BEST_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Best <= '1;
      end else if (state == IDLE && Start) begin
         Best <= '1;
      end else if (handshake && (OutData < Best)) begin
         Best <= OutData;
      end
   end
`endif

endmodule
